fetch_unit: RTL and testbench

- Instruction fetch front end sitting directly upstream of the decode/control/ALU datapath.
- Owns the program counter and issues word reads to the synchronous instruction memory.
- Buffers returned instructions with their PCs in a small queue and presents them to the consumer over a valid/ready handshake.
- Accepts a branch/jump redirect that flushes all buffered and in-flight work and restarts fetch at the new PC.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, reset constant and queue entry type for the instruction fetch front end.
package fetch_pkg;

    localparam int PC_WIDTH            = 16;
    localparam int INSTR_WIDTH         = 32;
    localparam int DEFAULT_QUEUE_DEPTH = 4;

    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory read port, redirect input and consumer handshake.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   out_valid;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_pc;
    logic                   out_ready;
    logic [PC_WIDTH-1:0]    fetch_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_pc,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_pc,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous clear, occupancy count and same-cycle push+pop (even when full).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited imem reads, queues responses, handles redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                inflight_q, inflight_d;

    logic                issue, push, pop;
    logic                fifo_empty, fifo_full;
    logic [CW-1:0]       fifo_count, credit_used;
    fetch_entry_t        resp_entry, head_entry;

    // An inflight read already owns a slot, so it counts against the queue before it lands.
    assign credit_used = fifo_count + CW'(inflight_q);
    assign issue       = !rst && !bus.redirect_valid && (credit_used < CW'(QUEUE_DEPTH));
    assign push        = inflight_q && !rst && !bus.redirect_valid;
    assign pop         = bus.out_valid && bus.out_ready;
    assign resp_entry  = '{pc: inflight_pc_q, instr: bus.imem_rdata};

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.fetch_pc  = fetch_pc_q;
    assign bus.out_valid = !rst && !bus.redirect_valid && !fifo_empty;
    assign bus.out_pc    = (rst || fifo_empty) ? '0 : head_entry.pc;
    assign bus.out_instr = (rst || fifo_empty) ? '0 : head_entry.instr;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.redirect_valid),
        .push_i  (push),
        .wdata_i (resp_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    // The credit check makes a response landing in a full queue without a pop impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle model plus in-order (pc, instr) scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        int                     cyc;
    } exp_entry_t;

    logic                clk = 1'b0;
    logic                rst;
    int                  checks = 0;
    int                  errors = 0;
    int                  cyc    = 0;
    logic [PC_WIDTH-1:0] model_addr = RESET_PC;
    exp_entry_t          sb[$];

    fetch_unit_if bus ();

    fetch_unit #(
        .QUEUE_DEPTH (DEFAULT_QUEUE_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_WIDTH-1:0] mem_word(input logic [PC_WIDTH-1:0] a);
        return 32'h1000_0000 + INSTR_WIDTH'(a);
    endfunction

    // Synchronous instruction memory: data valid exactly one cycle after the request.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare on the falling edge, then advance the model to the state after the next rising edge.
    always @(negedge clk) begin
        logic exp_req, exp_valid;
        exp_req   = !rst && !bus.redirect_valid && (sb.size() < DEFAULT_QUEUE_DEPTH);
        exp_valid = !rst && !bus.redirect_valid && (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);

        check("imem_req",  64'(bus.imem_req),  64'(exp_req));
        check("fetch_pc",  64'(bus.fetch_pc),  64'(model_addr));
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        if (exp_req) check("imem_addr", 64'(bus.imem_addr), 64'(model_addr));
        if (exp_valid) begin
            check("out_pc",    64'(bus.out_pc),    64'(sb[0].pc));
            check("out_instr", 64'(bus.out_instr), 64'(sb[0].instr));
        end else if (rst || sb.size() == 0) begin
            check("out_pc_zero",    64'(bus.out_pc),    64'(0));
            check("out_instr_zero", 64'(bus.out_instr), 64'(0));
        end

        if (rst) begin
            sb.delete();
            model_addr = RESET_PC;
        end else if (bus.redirect_valid) begin
            sb.delete();
            model_addr = bus.redirect_pc;
        end else begin
            if (exp_valid && bus.out_ready) void'(sb.pop_front());
            if (exp_req) begin
                sb.push_back('{pc: model_addr, instr: mem_word(model_addr), cyc: cyc});
                model_addr = model_addr + PC_WIDTH'(1);
            end
        end
        cyc++;
    end

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        step(2);

        // Free-running fetch from reset.
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step(12);

        // Consumer stalled from reset: four requests then idle, then drain and resume.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        step(8);
        bus.out_ready = 1'b1;
        step(6);

        // Build three queued plus one inflight, then pulse a redirect.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        step(7);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        step(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        step(1);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        step(8);

        // Redirect near the top of the address space to exercise wrap.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFE;
        step(1);
        bus.redirect_valid = 1'b0;
        step(8);

        // Redirect held for several cycles with a changing target.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0100;
        step(1);
        bus.redirect_pc    = 16'h0200;
        step(1);
        bus.redirect_pc    = 16'h0300;
        step(1);
        bus.redirect_valid = 1'b0;
        step(6);

        // Random consumer backpressure.
        repeat (1000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step(1);
        end

        // Reset pulse with a full queue.
        bus.out_ready = 1'b0;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
